cic_interpolator: RTL and testbench
===================================

# cic_interpolator

Transmit-path CIC interpolator: accepts low-rate signed samples from upstream, zero-stuffs by INTERPOLATION, and filters through STAGES comb and STAGES integrator sections to produce one output sample per high-rate tick. It is the transmit-side counterpart of the receive CIC decimator. It sits between the TX FIR/compensation stage (upstream) and the DAC/upconverter (downstream). The downstream side paces it with `out_strobe`, and it requests data from upstream with `in_strobe`.

## Interface
- STAGES, 3: number of comb and number of integrator sections (≥1).
- INTERPOLATION, 16: rate change R; power of two, ≥2.
- IN_WIDTH, 18: signed input width.
- OUT_WIDTH, IN_WIDTH: signed output width (≤ IN_WIDTH + 1).
- ACC_WIDTH, IN_WIDTH + STAGES*$clog2(INTERPOLATION): internal comb/integrator width.
- SHIFT (localparam), (STAGES-1)*$clog2(INTERPOLATION): gain-normalising right shift.
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- out_strobe  input  1  high-rate tick from downstream; one output sample per clock cycle in which it is high.
- in_strobe  output  1  registered one-clock pulse; means in_data was consumed and upstream may present the next sample.
- in_data  input  IN_WIDTH  signed sample; must be stable in every cycle in which a capture can occur.
- out_data  output  OUT_WIDTH  signed, registered output sample.

## Operation
- Phase counter `phase`, 0..R-1, advances by 1 (wrapping R-1→0) on each out_strobe and holds otherwise.
- Capture event: out_strobe=1 and phase==0.
- On a capture event:
  - in_data is sign-extended to ACC_WIDTH.
  - Every comb register k (k=1..STAGES) updates: c[k] <= d[k-1] - d_prev[k-1], with d_prev[k-1] <= d[k-1].
  - d[0] is the extended in_data and d[k] is c[k].
  - All stages update in the same cycle and use pre-update values, giving a pipelined comb chain.
- Upsampler / integrator input u, evaluated on each out_strobe: u = c[STAGES] (pre-update value) when phase==0, else 0.
- On each out_strobe, integrators update: i[1] <= i[1]+u and i[k] <= i[k]+i[k-1] (pre-update values).
- Output stage, on each out_strobe:
  - r = (i[STAGES] >>> SHIFT) + i[STAGES][SHIFT-1].
  - This rounds half up; when SHIFT==0 the rounding term is 0.
  - r is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and registered into out_data.
- Arithmetic:
  - All comb and integrator arithmetic is two's-complement at ACC_WIDTH, and wrap-around is intended.
  - Only the rounded result is saturated.
- DC gain is R^(STAGES-1), which SHIFT removes exactly, so a constant input X yields out_data == X in steady state.
- With no out_strobe, all state holds. in_data is ignored outside capture events.

## Timing
- Reset values:
  - phase = 0.
  - All comb, delay and integrator registers = 0.
  - out_data = 0.
  - in_strobe = 0.
- Reset asserted mid-operation clears all state immediately (asynchronous assertion). After release, the first out_strobe is a capture event.
- in_strobe rises the clock after a capture event and stays high for exactly one clock. Consecutive pulses are separated by exactly R out_strobes.
- When out_strobe is high every clock, in_strobe has a period of R clocks.
- out_data changes only in the clock after an out_strobe.
- Latency, counted in out_strobes after a capture:
  - Comb path: a sample first reaches u at the capture STAGES input samples later.
  - Integrator chain: STAGES out_strobes to reach i[STAGES], plus 1 for the output register.
  - A step settles no later than 2*STAGES*R + STAGES + 2 out_strobes after its first capture.
- The impulse response is non-negative, so step responses are monotonic and there is no overshoot.
- Back-to-back out_strobe, including every clock, is fully supported. There is no minimum gap.

## Test plan
- Reset then out_strobe every clock, in_data=0 → out_data stays 0; in_strobe pulses at clocks 1, 17, 33, … (one cycle after each capture), each exactly 1 clock wide.
- Defaults, constant in_data=1000 from reset, out_strobe every clock → out_data non-decreasing, reaches exactly 1000 within 101 out_strobes and stays 1000.
- in_data=+131071 constant, then -131072 constant → out_data settles to exactly 131071, then monotonically to exactly -131072; never wraps sign.
- out_strobe every 3rd clock, in_data=-500 → in_strobe period 48 clocks; out_data updates only the clock after each out_strobe; settles to exactly -500.
- Alternating ±131071 per input sample, 200 input samples → out_data always within [-131072, 131071], no sign wrap, mean over the final 32 input samples ≈ 0.
- Mid-stream reset pulse while output=1000 → out_data, in_strobe 0 immediately; after release the first out_strobe captures in_data and the step response repeats identically to scenario 2.

Source files
------------

// File: rtl/cic_interpolator.sv
// CIC interpolator: pipelined low-rate comb chain, zero-stuffing by INTERPOLATION,
// high-rate integrator chain, then round-half-up, saturate and register the output.
module cic_interpolator #(
  parameter int STAGES        = 3,
  parameter int INTERPOLATION = 16,
  parameter int IN_WIDTH      = 18,
  parameter int OUT_WIDTH     = IN_WIDTH,
  parameter int ACC_WIDTH     = IN_WIDTH + STAGES*$clog2(INTERPOLATION)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        out_strobe,
  output logic                        in_strobe,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  localparam int LOG_R = $clog2(INTERPOLATION);
  localparam int SHIFT = (STAGES-1)*LOG_R;

  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [LOG_R-1:0]            phase_q, phase_d;
  logic signed [ACC_WIDTH-1:0] comb_q  [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_d  [STAGES];
  logic signed [ACC_WIDTH-1:0] dly_q   [STAGES];
  logic signed [ACC_WIDTH-1:0] dly_d   [STAGES];
  logic signed [ACC_WIDTH-1:0] integ_q [STAGES];
  logic signed [ACC_WIDTH-1:0] integ_d [STAGES];
  logic signed [OUT_WIDTH-1:0] out_q, out_d;
  logic                        in_strobe_q, in_strobe_d;
  logic                        capture;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] upsamp;
  logic signed [ACC_WIDTH:0]   rnd;

  assign capture = out_strobe && (phase_q == '0);
  assign in_ext  = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign upsamp  = (phase_q == '0) ? comb_q[STAGES-1] : '0;

  // Array index k holds comb stage k+1; dly_q[k] is the previous input of that stage.
  always_comb begin
    comb_d = comb_q;
    dly_d  = dly_q;
    if (capture) begin
      comb_d[0] = in_ext - dly_q[0];
      dly_d[0]  = in_ext;
      for (int unsigned k = 1; k < STAGES; k++) begin
        comb_d[k] = comb_q[k-1] - dly_q[k];
        dly_d[k]  = comb_q[k-1];
      end
    end
  end

  always_comb begin
    integ_d = integ_q;
    phase_d = phase_q;
    if (out_strobe) begin
      phase_d    = phase_q + 1'b1;
      integ_d[0] = integ_q[0] + upsamp;
      for (int unsigned k = 1; k < STAGES; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  generate
    if (SHIFT > 0) begin : g_round
      logic signed [ACC_WIDTH-1:0] shifted;
      assign shifted = integ_q[STAGES-1] >>> SHIFT;
      assign rnd = {shifted[ACC_WIDTH-1], shifted}
                 + {{ACC_WIDTH{1'b0}}, integ_q[STAGES-1][SHIFT-1]};
    end else begin : g_noround
      assign rnd = {integ_q[STAGES-1][ACC_WIDTH-1], integ_q[STAGES-1]};
    end
  endgenerate

  always_comb begin
    out_d = out_q;
    if (out_strobe) begin
      if (rnd > OUT_MAX) begin
        out_d = OUT_MAX[OUT_WIDTH-1:0];
      end else if (rnd < OUT_MIN) begin
        out_d = OUT_MIN[OUT_WIDTH-1:0];
      end else begin
        out_d = rnd[OUT_WIDTH-1:0];
      end
    end
  end

  assign in_strobe_d = capture;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q     <= '0;
      comb_q      <= '{default: '0};
      dly_q       <= '{default: '0};
      integ_q     <= '{default: '0};
      out_q       <= '0;
      in_strobe_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      comb_q      <= comb_d;
      dly_q       <= dly_d;
      integ_q     <= integ_d;
      out_q       <= out_d;
      in_strobe_q <= in_strobe_d;
    end
  end

  assign out_data  = out_q;
  assign in_strobe = in_strobe_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench for cic_interpolator: expected outputs come from a direct
// convolution of the zero-stuffed input with the (boxcar)^STAGES impulse response.
module tb_cic_interpolator;

  localparam int S     = 3;
  localparam int R     = 16;
  localparam int IW    = 18;
  localparam int OW    = 18;
  localparam int SHIFT = (S-1)*$clog2(R);
  localparam int HLEN  = S*(R-1)+1;
  localparam int LAT   = S*R + S;
  localparam longint MAXV = (64'sd1 <<< (OW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OW-1));

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 out_strobe;
  logic                 in_strobe;
  logic signed [IW-1:0] in_data;
  logic signed [OW-1:0] out_data;

  always #5 clock = ~clock;

  cic_interpolator #(
    .STAGES(S),
    .INTERPOLATION(R),
    .IN_WIDTH(IW),
    .OUT_WIDTH(OW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .out_strobe(out_strobe),
    .in_strobe(in_strobe),
    .in_data(in_data),
    .out_data(out_data)
  );

  typedef struct {
    longint out;
    logic   instb;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     failures = 0;
  longint h[HLEN];
  longint xs[4096];
  int     ncap;
  int     t;
  longint last_exp;
  int     mode;
  longint cval;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sample(input int n);
    if (mode == 1) return (n % 2 == 0) ? 64'sd131071 : -64'sd131071;
    return cval;
  endfunction

  // Output after the tt-th out_strobe since reset.
  function automatic longint model_out(input int tt);
    longint g = 0;
    int m = tt - LAT;
    for (int j = 0; j < HLEN; j++) begin
      int p = m - j;
      if (p >= 0 && (p % R) == 0 && (p / R) < ncap) g += h[j] * xs[p / R];
    end
    g = (g + (64'sd1 <<< (SHIFT-1))) >>> SHIFT;
    if (g > MAXV) g = MAXV;
    if (g < MINV) g = MINV;
    return g;
  endfunction

  task automatic model_reset();
    ncap = 0;
    t = 0;
    last_exp = 0;
    sb_q.delete();
  endtask

  task automatic step(input logic stb);
    exp_t   e;
    exp_t   got_e;
    longint sv;
    out_strobe = stb;
    in_data = IW'($urandom());
    e.instb = 1'b0;
    e.out = last_exp;
    if (stb) begin
      if (t % R == 0) begin
        sv = sample(ncap);
        in_data = sv[IW-1:0];
        xs[ncap] = sv;
        ncap++;
        e.instb = 1'b1;
      end
      e.out = model_out(t);
      last_exp = e.out;
      t++;
    end
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 0, 1);
    end else begin
      got_e = sb_q.pop_front();
      check_eq("out_data", out_data, got_e.out);
      check_eq("in_strobe", in_strobe, got_e.instb);
    end
  endtask

  task automatic do_reset();
    out_strobe = 1'b0;
    in_data = '0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_strobe", in_strobe, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    longint a[HLEN];
    longint b[HLEN];
    longint sum;

    for (int i = 0; i < HLEN; i++) a[i] = 0;
    a[0] = 1;
    for (int s = 0; s < S; s++) begin
      for (int i = 0; i < HLEN; i++) b[i] = 0;
      for (int i = 0; i < HLEN; i++)
        for (int j = 0; j < R; j++)
          if (i + j < HLEN) b[i+j] += a[i];
      a = b;
    end
    h = a;

    mode = 0;
    cval = 0;
    do_reset();
    for (int i = 0; i < 48; i++) step(1'b1);

    cval = 1000;
    do_reset();
    for (int i = 0; i < 120; i++) step(1'b1);
    check_eq("dc_1000", out_data, 1000);

    cval = 131071;
    do_reset();
    for (int i = 0; i < 12*R; i++) step(1'b1);
    check_eq("dc_pos_max", out_data, 131071);
    cval = -131072;
    for (int i = 0; i < 16*R; i++) step(1'b1);
    check_eq("dc_neg_max", out_data, -131072);

    cval = -500;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      step(1'b0);
      step(1'b0);
      step(1'b1);
    end
    check_eq("dc_m500", out_data, -500);

    mode = 1;
    do_reset();
    sum = 0;
    for (int i = 0; i < 200*R; i++) begin
      step(1'b1);
      if (i >= 168*R) sum += longint'(out_data);
    end
    check_eq("alt_mean_near_zero", longint'(sum >= -512 && sum <= 512), 1);

    mode = 0;
    cval = 1000;
    do_reset();
    for (int i = 0; i < 113; i++) step(1'b1);
    out_strobe = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_out_data", out_data, 0);
    check_eq("async_rst_in_strobe", in_strobe, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    for (int i = 0; i < 120; i++) step(1'b1);
    check_eq("dc_1000_after_rst", out_data, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
